// File: rtl/regfile_wb_if.sv
// Writeback bus between the two requesters, the decode-stage scoreboard
// and the register-file write port of regfile_wb_arbiter.
interface regfile_wb_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
);
    logic              stall;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   busy;
    logic              err_unrsv;

    modport slave (
        input  stall,
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  rsv_en, rsv_addr,
        output wr_en, wr_addr, wr_data, busy, err_unrsv
    );

    modport master (
        output stall,
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output rsv_en, rsv_addr,
        input  wr_en, wr_addr, wr_data, busy, err_unrsv
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback paths, with a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 31
) (
    input logic         clk,
    input logic         reset_n,
    regfile_wb_if.slave bus
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [NREG-1:0]   r_busy;
    logic              r_err;

    logic              w_gnt_alu;
    logic              w_gnt_mem;
    logic              w_contested;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_commit;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_gnt_alu   = 1'b0;
        w_gnt_mem   = 1'b0;
        w_contested = 1'b0;
        w_set       = '0;
        w_clr       = '0;

        if (!bus.stall) begin
            if (bus.alu_valid && bus.mem_valid) begin
                w_contested = 1'b1;
                w_gnt_alu   = !r_ptr;
                w_gnt_mem   = r_ptr;
            end else begin
                w_gnt_alu = bus.alu_valid;
                w_gnt_mem = bus.mem_valid;
            end
        end

        w_gnt_addr = w_gnt_mem ? bus.mem_addr : bus.alu_addr;
        w_gnt_data = w_gnt_mem ? bus.mem_data : bus.alu_data;
        // Writes aimed at the hardwired-zero register are consumed but dropped.
        w_commit   = (w_gnt_alu || w_gnt_mem) && (w_gnt_addr != ZERO_ADDR);

        if (bus.rsv_en && (bus.rsv_addr != ZERO_ADDR)) begin
            w_set[bus.rsv_addr] = 1'b1;
        end
        if (r_wr_en) begin
            w_clr[r_wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset_n) begin
            r_ptr     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
        end else begin
            // A contested grant hands priority to the requester that just lost.
            if (w_contested) begin
                r_ptr <= ~r_ptr;
            end

            r_wr_en <= w_commit;
            if (w_commit) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
            end

            // Set after clear so a same-cycle re-reservation keeps the bit high.
            r_busy <= (r_busy & ~w_clr) | w_set;

            if (r_wr_en && !r_busy[r_wr_addr]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.alu_ready = w_gnt_alu;
    assign bus.mem_ready = w_gnt_mem;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.err_unrsv = r_err;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write stage,
// scoreboard and sticky error flag against hand-computed expectations.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .ZERO_REG(31)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Registered outputs are checked 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lets combinational grants settle after inputs change.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] exp_addr;

        reset_n = 1'b0;
        idle();
        tick();
        tick();
        check("rst_wr_en",   bus.wr_en,     0);
        check("rst_wr_addr", bus.wr_addr,   0);
        check("rst_wr_data", bus.wr_data,   0);
        check("rst_busy",    bus.busy,      0);
        check("rst_err",     bus.err_unrsv, 0);
        reset_n = 1'b1;

        // Single ALU writeback to a reserved register.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        tick();
        bus.rsv_en = 1'b0;
        check("rsv3_busy", bus.busy, 64'h8);
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 64'hAA;
        settle();
        check("single_alu_ready", bus.alu_ready, 1);
        check("single_mem_ready", bus.mem_ready, 0);
        tick();
        bus.alu_valid = 1'b0;
        check("single_wr_en",   bus.wr_en,   1);
        check("single_wr_addr", bus.wr_addr, 3);
        check("single_wr_data", bus.wr_data, 64'hAA);
        check("single_busy_hold", bus.busy,  64'h8);
        tick();
        check("single_wr_en_off", bus.wr_en,     0);
        check("single_busy_clr",  bus.busy,      0);
        check("single_err",       bus.err_unrsv, 0);

        // Contention: both requesters valid for four cycles.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd1;
        tick();
        bus.rsv_addr = 5'd2;
        tick();
        bus.rsv_en = 1'b0;
        check("rsv12_busy", bus.busy, 64'h6);
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 64'h11;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
            bus.rsv_en = 1'b1; bus.rsv_addr = exp_addr;
            settle();
            check("rr_alu_ready", bus.alu_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_mem_ready", bus.mem_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("rr_wr_en",   bus.wr_en,   1);
            check("rr_wr_addr", bus.wr_addr, exp_addr);
        end
        idle();
        check("rr_err", bus.err_unrsv, 0);

        // Hardwired-zero register: consumed, not written, never reserved.
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd31; bus.mem_data = 64'h55;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd31;
        settle();
        check("zero_mem_ready", bus.mem_ready, 1);
        check("zero_alu_ready", bus.alu_ready, 0);
        tick();
        idle();
        check("zero_wr_en",   bus.wr_en,     0);
        check("zero_wr_addr", bus.wr_addr,   2);
        check("zero_wr_data", bus.wr_data,   64'h22);
        check("zero_busy",    bus.busy,      0);
        check("zero_err",     bus.err_unrsv, 0);

        // Stall holds off both requesters; reservations still land.
        bus.stall = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 64'h11;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 64'h22;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_alu_ready", bus.alu_ready, 0);
            check("stall_mem_ready", bus.mem_ready, 0);
            tick();
            bus.rsv_en = 1'b0;
            check("stall_wr_en", bus.wr_en, 0);
        end
        check("stall_busy", bus.busy, 64'h2);
        bus.stall = 1'b0;
        settle();
        check("unstall_alu_ready", bus.alu_ready, 1);
        check("unstall_mem_ready", bus.mem_ready, 0);
        tick();
        idle();
        check("unstall_wr_en",   bus.wr_en,   1);
        check("unstall_wr_addr", bus.wr_addr, 1);
        check("unstall_wr_data", bus.wr_data, 64'h11);

        // Set/clear collision on X5: the new reservation wins.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
        tick();
        bus.rsv_en = 1'b0;
        check("coll_busy_pre", bus.busy, 64'h20);
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 64'h5A;
        settle();
        check("coll_alu_ready", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
        check("coll_wr_en",   bus.wr_en,   1);
        check("coll_wr_addr", bus.wr_addr, 5);
        tick();
        bus.rsv_en = 1'b0;
        check("coll_busy_post", bus.busy,      64'h20);
        check("coll_err",       bus.err_unrsv, 0);

        // Pointer favours MEM after the earlier contested ALU win.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 64'h77;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd31; bus.mem_data = 64'h0;
        settle();
        check("ptr_mem_ready", bus.mem_ready, 1);
        check("ptr_alu_ready", bus.alu_ready, 0);
        tick();
        bus.mem_valid = 1'b0;
        check("ptr_wr_en", bus.wr_en, 0);

        // Unreserved write to X7 raises the sticky error.
        settle();
        check("unrsv_alu_ready", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        check("unrsv_wr_en",   bus.wr_en,     1);
        check("unrsv_wr_addr", bus.wr_addr,   7);
        check("unrsv_wr_data", bus.wr_data,   64'h77);
        check("unrsv_err_pre", bus.err_unrsv, 0);
        tick();
        check("unrsv_err_set", bus.err_unrsv, 1);
        check("unrsv_wr_off",  bus.wr_en,     0);
        tick();
        check("unrsv_err_sticky", bus.err_unrsv, 1);

        // Reset during a grant cycle discards the grant.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 64'h33;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        reset_n = 1'b0;
        tick();
        check("rst2_wr_en",   bus.wr_en,     0);
        check("rst2_wr_addr", bus.wr_addr,   0);
        check("rst2_wr_data", bus.wr_data,   0);
        check("rst2_busy",    bus.busy,      0);
        check("rst2_err",     bus.err_unrsv, 0);
        reset_n = 1'b1;
        idle();
        tick();
        check("rst2_no_write", bus.wr_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU/execute path and the load/memory path.
- Drives the registered write address and enable that feed the register file's 5-to-32 write-select decoder, plus the write data.
- Keeps a 32-entry pending-write scoreboard so the decode stage can stall on RAW hazards.
- Arbitration is round-robin. Register 31 is hardwired zero and is never written.

Parameters:
DATA_W, 64, width of write data
ADDR_W, 5, register address width (decoder input width)
NREG, 32, number of registers (2**ADDR_W)
ZERO_REG, 31, hardwired-zero register index

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  reset, synchronous and active-low
stall  in  1  hazard-unit freeze; no grants while high
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request granted this cycle
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
rsv_en  in  1  decode reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
wr_en  out  1  register-file write enable (decoder en)
wr_addr  out  ADDR_W  register-file write address (decoder in)
wr_data  out  DATA_W  register-file write data
busy  out  NREG  scoreboard; bit r = write to r outstanding
err_unrsv  out  1  sticky: a write committed to an unreserved register

Behaviour:
- Reset (reset_n low at a clock edge) forces:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, err_unrsv=0.
  - Priority pointer ptr=0 (ALU favoured).
- Reset overrides every other input in the same cycle. A grant in progress is discarded; no write occurs on the following cycle.
- Grant logic (combinational, same cycle as valid):
  - If stall=1: alu_ready=mem_ready=0.
  - Else if only one requester is valid, that one is granted.
  - Else if both are valid, grant ALU when ptr=0 and MEM when ptr=1.
  - At most one ready is high per cycle. ready is never high without its valid.
- Pointer update:
  - Only on a contested grant (both valid, stall=0): ptr flips to favour the loser.
  - Uncontested grants leave ptr unchanged.
- Write stage (registered, latency 1):
  - The granted addr and data are captured at the edge.
  - wr_en=1 for exactly one cycle, unless the granted addr = ZERO_REG. In that case wr_en=0, the request is still consumed (ready=1), and wr_addr/wr_data hold their previous values.
  - With no grant, wr_en=0 and wr_addr/wr_data hold.
- Back-to-back grants give consecutive wr_en pulses; throughput is one write per cycle.
- Scoreboard (updated at each edge):
  - Set: rsv_en=1 and rsv_addr!=ZERO_REG sets busy[rsv_addr]. Reservations to ZERO_REG are ignored; busy[ZERO_REG] is constant 0.
  - Clear: wr_en=1 in the current cycle clears busy[wr_addr].
  - Same register set and cleared in the same cycle: set wins, leaving busy=1 for the new reservation.
  - Re-reserving an already-busy register keeps it at 1; there is no count.
  - stall does not block reservations or clears.
- Error flag: if wr_en=1 and busy[wr_addr]=0 in the same cycle, err_unrsv is set. It clears only on reset. The write is still performed.
- Requesters must hold valid, addr and data stable until their ready is seen. The arbiter does not buffer ungranted requests.

Test Plan:
- Reset, then single ALU request: rsv X3, then alu_valid=1, addr=3, data=0xAA -> alu_ready same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xAA; busy[3] 1->0; err_unrsv=0.
- Contention: both valid continuously (ALU addr 1, MEM addr 2, both reserved) -> grants alternate ALU, MEM, ALU, MEM; wr_addr sequence 1,2,1,2 with wr_en high every cycle.
- Zero register: mem_valid with addr=31, data=0x55 -> mem_ready=1, next cycle wr_en=0; rsv_addr=31 leaves busy=0.
- Stall: both valid with stall=1 for 3 cycles -> both readies 0, wr_en=0. Release -> ALU granted first (ptr still 0).
- Set/clear collision: X5 busy, its write commits in the same cycle as rsv_en with rsv_addr=5 -> busy[5] remains 1.
- Unreserved write, then reset: alu write to X7 with busy[7]=0 -> err_unrsv=1 and stays set. reset_n=0 during a grant cycle -> next cycle wr_en=0, busy=0, err_unrsv=0.
